// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared constants, Rcon table and FSM encoding for the
// AES-128 key schedule sequencer (key_expansion_ctrl, key_round_step).
package aes_key_pkg;

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam logic [3:0]  LAST_RND   = NUM_ROUNDS[3:0];

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        STEP,
        FIN
    } kx_state_e;

    // Round constant for round r, placed in the top byte; 0 outside 1..10.
    function automatic logic [31:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 32'h0100_0000;
            4'd2:    rcon = 32'h0200_0000;
            4'd3:    rcon = 32'h0400_0000;
            4'd4:    rcon = 32'h0800_0000;
            4'd5:    rcon = 32'h1000_0000;
            4'd6:    rcon = 32'h2000_0000;
            4'd7:    rcon = 32'h4000_0000;
            4'd8:    rcon = 32'h8000_0000;
            4'd9:    rcon = 32'h1B00_0000;
            4'd10:   rcon = 32'h3600_0000;
            default: rcon = '0;
        endcase
    endfunction

endpackage

// File: rtl/key_round_step.sv
// key_round_step: combinational one-round AES-128 key step.
// Bit 127 of a key here is bit 0 of the FIPS-197 [0:127] ordering, so w0 is
// the top word and hex literals read the same as the standard's vectors.
module key_round_step
    import aes_key_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key,
    input  logic [3:0]       round,
    output logic [KEY_W-1:0] next_key
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    // First word from RotWord/SubWord/Rcon on w3, then the XOR chain.
    always_comb begin
        {w0, w1, w2, w3} = prev_key;
        n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ rcon(round);
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: AES-128 key schedule sequencer streaming round keys
// 0..10 over a valid/ready handshake.
// Optional feature macro KEY_STORE_EN adds an 11-entry round-key store with a
// combinational read port (rk_rd_idx / rk_rd_data).
// Key bit 127 corresponds to FIPS-197 bit 0 (first byte in the top bits).
module key_expansion_ctrl
    import aes_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_round,
    output logic [KEY_W-1:0] rk_data,
    output logic             done
`ifdef KEY_STORE_EN
    ,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data
`endif
);

    kx_state_e        state_q, state_d;
    logic [KEY_W-1:0] key_reg_q, key_reg_d;
    logic [KEY_W-1:0] rk_data_q, rk_data_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [KEY_W-1:0] step_key;
    logic             hs;
    logic             accept;

    assign hs     = rk_valid & rk_ready;
    assign accept = (state_q == IDLE) & start;

    key_round_step u_step (
        .prev_key (key_reg_q),
        .round    (rnd_q + 4'd1),
        .next_key (step_key)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. STEP is the cycle right after an advance; it presents
    // the new key and accepts a handshake exactly like EMIT, so a consumer
    // with rk_ready held high takes one key per cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = LOAD;
            LOAD:       state_d = EMIT;
            EMIT, STEP: begin
                if (hs) state_d = (rnd_q == LAST_RND) ? FIN : STEP;
                else    state_d = EMIT;
            end
            FIN:        state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        busy     = (state_q == LOAD) | (state_q == EMIT) | (state_q == STEP);
        rk_valid = (state_q == EMIT) | (state_q == STEP);
        done     = (state_q == FIN);
    end

    // Datapath next values: key capture, round counter and presented key.
    always_comb begin
        key_reg_d = key_reg_q;
        rk_data_d = rk_data_q;
        rnd_d     = rnd_q;
        if (accept) begin
            key_reg_d = key_in;
            rnd_d     = '0;
        end else if (state_q == LOAD) begin
            rk_data_d = key_reg_q;
        end else if (hs && rnd_q != LAST_RND) begin
            rnd_d     = rnd_q + 4'd1;
            key_reg_d = step_key;
            rk_data_d = step_key;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg_q <= '0;
            rk_data_q <= '0;
            rnd_q     <= '0;
        end else begin
            key_reg_q <= key_reg_d;
            rk_data_q <= rk_data_d;
            rnd_q     <= rnd_d;
        end
    end

    assign rk_round = rnd_q;
    assign rk_data  = rk_data_q;

`ifdef KEY_STORE_EN
    logic [KEY_W-1:0] store_q [NUM_ROUNDS+1];
    logic [KEY_W-1:0] store_d [NUM_ROUNDS+1];

    // Store update: cleared on accepted start, each key written as it is emitted.
    always_comb begin
        store_d = store_q;
        if (accept) begin
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store_d[i] = '0;
        end else if (state_q == LOAD) begin
            store_d[0] = key_reg_q;
        end else if (hs && rnd_q != LAST_RND) begin
            store_d[rnd_q + 4'd1] = step_key;
        end
    end

    // Store registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    assign rk_rd_data = (rk_rd_idx <= LAST_RND) ? store_q[rk_rd_idx] : '0;
`endif

endmodule
